// File: rtl/ysyx_041461_wb_stage.sv
// ysyx_041461_wb_stage: RV64 write-back stage owning the machine CSRs,
// trap redirect, commit trace and sticky ebreak halt.
module ysyx_041461_wb_stage #(
    parameter logic [63:0] RESET_PC    = 64'h0000_0000_3000_0000,
    parameter logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_enable,
    input  logic        wb_valid,
    input  logic [3:0]  wb_trap,
    input  logic [63:0] wb_exe,
    input  logic [63:0] wb_mem,
    input  logic [4:0]  wb_rd,
    input  logic [4:0]  wb_rs1,
    input  logic [11:0] wb_csr,
    input  logic [63:0] wb_imm,
    input  logic [63:0] wb_zimm,
    input  logic [63:0] wb_pc,
    input  logic [3:0]  wb_ctrl,
    input  logic [31:0] wb_inst,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        commit_valid,
    output logic [63:0] commit_pc,
    output logic [31:0] commit_inst,
    output logic        halt,
    output logic [63:0] halt_pc
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    logic        consumed;
    logic [63:0] mstatus, mtvec, mepc, mcause, mcycle, minstret;
    logic        fire, trap_nop, do_ecall, do_mret, do_ebreak, do_wb;
    logic        is_csr, is_imm_form, op_rw, op_rs, src_zero, csr_we;
    logic [63:0] csr_old, csr_src, csr_new, mstatus_ecall, mstatus_mret;

    assign fire      = wb_valid & ~consumed & ~halt;
    assign trap_nop  = ~(wb_trap == 4'd1 || wb_trap == 4'd2 || wb_trap == 4'd3);
    assign do_ecall  = fire & (wb_trap == 4'd1);
    assign do_mret   = fire & (wb_trap == 4'd2);
    assign do_ebreak = fire & (wb_trap == 4'd3);
    assign do_wb     = fire & trap_nop;

    assign is_csr      = wb_ctrl >= 4'd4 && wb_ctrl <= 4'd9;
    assign is_imm_form = wb_ctrl >= 4'd7;
    assign op_rw       = wb_ctrl == 4'd4 || wb_ctrl == 4'd7;
    assign op_rs       = wb_ctrl == 4'd5 || wb_ctrl == 4'd8;
    assign csr_src     = is_imm_form ? wb_zimm : wb_exe;
    assign src_zero    = is_imm_form ? (wb_zimm == 64'd0) : (wb_rs1 == 5'd0);
    assign csr_new     = op_rw ? csr_src : op_rs ? (csr_old | csr_src) : (csr_old & ~csr_src);
    // Set/clear with a zero source is a pure read and must not disturb the CSR.
    assign csr_we      = do_wb & is_csr & (op_rw | ~src_zero);

    always_comb begin
        case (wb_csr)
            A_MSTATUS:  csr_old = mstatus;
            A_MTVEC:    csr_old = mtvec;
            A_MEPC:     csr_old = mepc;
            A_MCAUSE:   csr_old = mcause;
            A_MCYCLE:   csr_old = mcycle;
            A_MINSTRET: csr_old = minstret;
            default:    csr_old = 64'd0;
        endcase
    end

    assign mstatus_ecall = {mstatus[63:13], 2'b11, mstatus[10:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]};
    assign mstatus_mret  = {mstatus[63:13], 2'b00, mstatus[10:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]};

    always_comb begin
        rf_wdata = 64'd0;
        if (do_wb) begin
            rf_wdata = wb_ctrl == 4'd1 ? wb_exe :
                       wb_ctrl == 4'd2 ? wb_mem :
                       wb_ctrl == 4'd3 ? wb_imm :
                       is_csr ? csr_old : 64'd0;
        end
    end

    assign rf_wen         = do_wb & (wb_ctrl >= 4'd1 && wb_ctrl <= 4'd9) & (wb_rd != 5'd0);
    assign rf_waddr       = do_wb ? wb_rd : 5'd0;
    assign redirect_valid = do_ecall | do_mret;
    assign redirect_pc    = do_ecall ? {mtvec[63:2], 2'b00} : do_mret ? mepc : 64'd0;
    assign commit_valid   = fire;
    assign commit_pc      = wb_pc;
    assign commit_inst    = fire ? wb_inst : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            consumed <= 1'b0;
            mstatus  <= MSTATUS_RST;
            mtvec    <= 64'd0;
            mepc     <= 64'd0;
            mcause   <= 64'd0;
            mcycle   <= 64'd0;
            minstret <= 64'd0;
            halt     <= 1'b0;
            halt_pc  <= RESET_PC;
        end else begin
            consumed <= wb_enable ? 1'b0 : (wb_valid | consumed);
            if (do_ebreak) begin
                halt    <= 1'b1;
                halt_pc <= wb_pc;
            end
            mstatus  <= (csr_we && wb_csr == A_MSTATUS) ? csr_new :
                        do_ecall ? mstatus_ecall : do_mret ? mstatus_mret : mstatus;
            mtvec    <= (csr_we && wb_csr == A_MTVEC) ? csr_new : mtvec;
            mepc     <= (csr_we && wb_csr == A_MEPC) ? csr_new : do_ecall ? wb_pc : mepc;
            mcause   <= (csr_we && wb_csr == A_MCAUSE) ? csr_new : do_ecall ? 64'd11 : mcause;
            mcycle   <= (csr_we && wb_csr == A_MCYCLE) ? csr_new : halt ? mcycle : mcycle + 64'd1;
            minstret <= (csr_we && wb_csr == A_MINSTRET) ? csr_new :
                        (fire & (trap_nop | do_mret)) ? minstret + 64'd1 : minstret;
        end
    end
endmodule
